// File: rtl/instruction_memory_sync.sv
// ---------------------------------------------------------------------------
// instruction_memory_sync
//
// Synchronous, writable instruction memory for the IF stage of the pipelined
// MIPS core. After reset the RAM is walked and filled with NOP_WORD (state
// CLEAR). Once cleared (state RUN), the program port may load words and the
// registered fetch port returns words with stall, flush and fault handling.
//
// Parameters:
//   DEPTH_LOG2   word-address width, depth = 2**DEPTH_LOG2 words
//   NOP_WORD     word returned on flush, fault, clear and reset
//
// Ports:
//   clk          clock, all state changes on rising edge
//   reset        asynchronous active-high reset, restarts the clear
//   Address      fetch byte address (PC)
//   stall        hold the fetch output register
//   flush        load NOP_WORD into the fetch register, beats stall
//   Instruction  registered fetched word
//   fetch_fault  registered, fetch was misaligned or out of range
//   prog_we      program-port write strobe
//   prog_addr    program-port byte address
//   prog_data    program-port write data
//   prog_ready   program port accepts writes (state RUN)
//   prog_err     one-cycle pulse after a rejected prog_we
// ---------------------------------------------------------------------------
module instruction_memory_sync #(
  parameter int          DEPTH_LOG2 = 8,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic        stall,
  input  logic        flush,
  output logic [31:0] Instruction,
  output logic        fetch_fault,
  input  logic        prog_we,
  input  logic [31:0] prog_addr,
  input  logic [31:0] prog_data,
  output logic        prog_ready,
  output logic        prog_err
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DEPTH_LOG2-1:0] clr_cnt;
  logic [31:0]           mem [DEPTH];

  logic                  fetch_ok;
  logic                  wr_ok;
  logic                  wr_accept;
  logic [DEPTH_LOG2-1:0] fetch_idx;
  logic [DEPTH_LOG2-1:0] wr_idx;

  // A byte address is usable when word-aligned and every bit above the
  // word index is zero.
  function automatic logic addr_ok(input logic [31:0] a);
    return (a[1:0] == 2'b00) && ((a >> (DEPTH_LOG2 + 2)) == 32'd0);
  endfunction

  assign fetch_ok  = addr_ok(Address);
  assign wr_ok     = addr_ok(prog_addr);
  assign fetch_idx = Address[DEPTH_LOG2+1:2];
  assign wr_idx    = prog_addr[DEPTH_LOG2+1:2];
  assign wr_accept = (state == RUN) && prog_we && wr_ok;

  // prog_ready is a pure decode of the state flop, so it still has no
  // combinational path from any input.
  assign prog_ready = (state == RUN);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= CLEAR;
    else       state <= state_next;
  end

  // NOTE: next-state gets its default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      CLEAR:   if (clr_cnt == '1) state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               clr_cnt <= '0;
    else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
  end

  // ---------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------
  // NOTE: the array has no reset term; it maps onto RAM macros that cannot be
  // reset in one cycle, so the CLEAR walk zeroes it one word per edge.
  always_ff @(posedge clk) begin
    if (state == CLEAR)  mem[clr_cnt] <= NOP_WORD;
    else if (wr_accept)  mem[wr_idx]  <= prog_data;
  end

  // ---------------------------------------------------------------------
  // Fetch register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      Instruction <= NOP_WORD;
      fetch_fault <= 1'b0;
    end else if (state == CLEAR) begin
      Instruction <= NOP_WORD;
      fetch_fault <= 1'b0;
    end else if (flush) begin
      Instruction <= NOP_WORD;
      fetch_fault <= 1'b0;
    end else if (stall && !fetch_fault) begin
      // Hold. A latched fault is not held by stall; the next fetch replaces it.
      Instruction <= Instruction;
      fetch_fault <= fetch_fault;
    end else if (!fetch_ok) begin
      Instruction <= NOP_WORD;
      fetch_fault <= 1'b1;
    end else if (wr_accept && (wr_idx == fetch_idx)) begin
      // Write-first: the RAM still holds the old word on this edge.
      Instruction <= prog_data;
      fetch_fault <= 1'b0;
    end else begin
      Instruction <= mem[fetch_idx];
      fetch_fault <= 1'b0;
    end
  end

  // Rejected writes: bad address, or any write while still clearing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) prog_err <= 1'b0;
    else       prog_err <= prog_we && !wr_accept;
  end

endmodule

// File: tb/tb_instruction_memory_sync.sv
// ---------------------------------------------------------------------------
// tb_instruction_memory_sync
//
// Directed bench for instruction_memory_sync at DEPTH_LOG2 = 4 (16 words,
// byte range 0x00-0x3F). Each stimulus cycle pushes its hand-computed
// post-edge response into a queue; a monitor on the falling edge pops and
// compares it against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_instruction_memory_sync;

  localparam int DL2 = 4;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic        stall;
  logic        flush;
  logic [31:0] Instruction;
  logic        fetch_fault;
  logic        prog_we;
  logic [31:0] prog_addr;
  logic [31:0] prog_data;
  logic        prog_ready;
  logic        prog_err;

  instruction_memory_sync #(
    .DEPTH_LOG2 (DL2),
    .NOP_WORD   (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .Address     (Address),
    .stall       (stall),
    .flush       (flush),
    .Instruction (Instruction),
    .fetch_fault (fetch_fault),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .prog_ready  (prog_ready),
    .prog_err    (prog_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] instr;
    logic        fault;
    logic        ready;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_id  = 0;

  task automatic check(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, req);
    end
  endtask

  // Monitor: outputs are stable half a period after the edge that produced them.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("instruction", e.id, Instruction, e.instr);
      check("fetch_fault", e.id, {31'd0, fetch_fault}, {31'd0, e.fault});
      check("prog_ready",  e.id, {31'd0, prog_ready},  {31'd0, e.ready});
      check("prog_err",    e.id, {31'd0, prog_err},    {31'd0, e.err});
    end
  end

  // One clock of stimulus plus its expected post-edge response.
  task automatic step(input logic rst_v, input logic [31:0] a,
                      input logic st, input logic fl,
                      input logic we, input logic [31:0] pa, input logic [31:0] pd,
                      input logic [31:0] ei, input logic ef,
                      input logic er, input logic ee);
    exp_t e;
    reset     = rst_v;
    Address   = a;
    stall     = st;
    flush     = fl;
    prog_we   = we;
    prog_addr = pa;
    prog_data = pd;
    @(posedge clk);
    step_id++;
    e.id = step_id; e.instr = ei; e.fault = ef; e.ready = er; e.err = ee;
    sb.push_back(e);
    #1;
  endtask

  // Plain RUN-state fetch, no program write.
  task automatic fetch(input logic [31:0] a, input logic [31:0] ei, input logic ef);
    step(1'b0, a, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, ei, ef, 1'b1, 1'b0);
  endtask

  // Release reset and walk the 16 clear edges; stall/flush toggled and a
  // write to 0x004 attempted at edge 14 must all be ignored.
  task automatic clear_phase();
    for (int i = 1; i <= 16; i++) begin
      step(1'b0, 32'h3C, (i == 3), (i == 5), (i == 14), 32'h004, 32'hDEAD_BEEF,
           32'h0, 1'b0, (i == 16), (i == 14));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; Address = '0; stall = 1'b0; flush = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_data = '0;

    // Held in reset: everything at its reset value.
    step(1'b1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);
    step(1'b1, 32'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);

    clear_phase();

    // First RUN fetches: last word and the word targeted during CLEAR are 0.
    fetch(32'h03C, 32'h0, 1'b0);
    fetch(32'h004, 32'h0, 1'b0);

    // Program load while fetching an unrelated word.
    step(0, 32'h03C, 0, 0, 1, 32'h000, 32'h2004_0005, 32'h0, 0, 1, 0);
    step(0, 32'h03C, 0, 0, 1, 32'h004, 32'h0000_1026, 32'h0, 0, 1, 0);
    step(0, 32'h03C, 0, 0, 1, 32'h008, 32'h0C00_0004, 32'h0, 0, 1, 0);
    fetch(32'h000, 32'h2004_0005, 1'b0);
    fetch(32'h004, 32'h0000_1026, 1'b0);
    fetch(32'h008, 32'h0C00_0004, 1'b0);

    // Stall three cycles, then stall+flush, then release.
    for (int i = 0; i < 3; i++)
      step(0, 32'h004, 1, 0, 0, 32'h0, 32'h0, 32'h0C00_0004, 0, 1, 0);
    step(0, 32'h004, 1, 1, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
    fetch(32'h004, 32'h0000_1026, 1'b0);

    // Faults: misaligned, first out-of-range word, far out of range, recovery.
    fetch(32'h006, 32'h0, 1'b1);
    fetch(32'h040, 32'h0, 1'b1);
    fetch(32'h400, 32'h0, 1'b1);
    fetch(32'h000, 32'h2004_0005, 1'b0);

    // Write-first bypass, then the word persists.
    step(0, 32'h010, 0, 0, 1, 32'h010, 32'h1000_FFFF, 32'h1000_FFFF, 0, 1, 0);
    fetch(32'h010, 32'h1000_FFFF, 1'b0);

    // Misaligned write rejected; word 4 unchanged.
    step(0, 32'h03C, 0, 0, 1, 32'h011, 32'hBAD0_BAD0, 32'h0, 0, 1, 1);
    fetch(32'h010, 32'h1000_FFFF, 1'b0);

    // Out-of-range write rejected; word 1 unchanged, no bypass.
    step(0, 32'h004, 0, 0, 1, 32'h044, 32'h1111_1111, 32'h0000_1026, 0, 1, 1);
    fetch(32'h004, 32'h0000_1026, 1'b0);

    // Back-to-back rejects keep prog_err high, then it drops.
    step(0, 32'h03C, 0, 0, 1, 32'h011, 32'h2222_2222, 32'h0, 0, 1, 1);
    step(0, 32'h03C, 0, 0, 1, 32'h011, 32'h2222_2222, 32'h0, 0, 1, 1);
    fetch(32'h010, 32'h1000_FFFF, 1'b0);

    // Flush alone, then normal fetch.
    step(0, 32'h000, 0, 1, 0, 32'h0, 32'h0, 32'h0, 0, 1, 0);
    fetch(32'h000, 32'h2004_0005, 1'b0);

    // Asynchronous reset between edges, after the monitor has drained.
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_instruction", step_id, Instruction, 32'h0);
    check("async_rst_ready", step_id, {31'd0, prog_ready}, 32'h0);
    step(1'b1, 32'h000, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 0);

    // Full clear again; old program is gone.
    clear_phase();
    fetch(32'h000, 32'h0, 1'b0);
    fetch(32'h010, 32'h0, 1'b0);
    fetch(32'h004, 32'h0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected responses never compared, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
